store_queue_fwd: RTL and testbench

- Parametrised, circular store queue for the dual-issue out-of-order core; it replaces the fixed-depth, dispatch-only store queue.
- Allocates up to two stores per cycle in program order and accepts address and data writebacks out of order.
- Retires stores on ROB commit, drains committed stores to the data cache through a valid/ready handshake, and forwards store data to younger loads.
- Supports a pipeline flush that discards every uncommitted entry.

---
 rtl/store_queue_fwd_if.sv | 30 +++
 rtl/store_queue_fwd.sv | 230 +++++++++++++++++++++++
 tb/tb_store_queue_fwd.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_queue_fwd_if.sv
// Store-queue to data-cache drain channel.
//   master (store queue): drives mem_req_valid / mem_req_addr / mem_req_data,
//                         samples mem_req_ready.
//   slave  (cache):       the reverse.
// Handshake: a transfer happens on a rising clk edge where mem_req_valid and
// mem_req_ready are both high. The master keeps valid/addr/data stable while
// valid is high and ready is low. Ready may depend combinationally on valid.
interface store_queue_fwd_if #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  logic                mem_req_valid;
  logic [ADDR_LEN-1:0] mem_req_addr;
  logic [DATA_LEN-1:0] mem_req_data;
  logic                mem_req_ready;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    output mem_req_data,
    input  mem_req_ready
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    input  mem_req_data,
    output mem_req_ready
  );
endinterface

// File: rtl/store_queue_fwd.sv
// Circular store queue with store-to-load forwarding.
//   Dispatch : disp_valid_1/2 + disp_rob_idx_1/2 in; disp_ack, disp_sq_idx_1/2 out.
//              All-or-nothing allocation of up to two stores, slot 1 older.
//   Writeback: addr_wb_* / data_wb_* set address / data of an uncommitted entry.
//   Commit   : commit_cnt (0..2) marks the oldest uncommitted entries committed.
//   Flush    : discards every uncommitted entry after that cycle's commit.
//   Drain    : mem (store_queue_fwd_if.master) carries committed head stores
//              to the cache, one per cycle.
//   Forward  : ld_valid/ld_addr/ld_sq_tail in; fwd_hit/fwd_data/fwd_stall out,
//              combinational.
//   Status   : sq_free, sq_empty.
//   Debug    : dbg_head/dbg_cmt/dbg_tail pointers, ROB tag of the head entry.
// Pointers carry one extra wrap bit above the entry index.
module store_queue_fwd #(
  parameter int SQ_DEPTH = 16,
  parameter int SQ_SEL   = $clog2(SQ_DEPTH),
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int ROB_SEL  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                disp_valid_1,
  input  logic                disp_valid_2,
  input  logic [ROB_SEL-1:0]  disp_rob_idx_1,
  input  logic [ROB_SEL-1:0]  disp_rob_idx_2,
  output logic                disp_ack,
  output logic [SQ_SEL:0]     disp_sq_idx_1,
  output logic [SQ_SEL:0]     disp_sq_idx_2,
  output logic [SQ_SEL:0]     sq_free,
  output logic                sq_empty,
  input  logic                addr_wb_valid,
  input  logic [SQ_SEL-1:0]   addr_wb_idx,
  input  logic [ADDR_LEN-1:0] addr_wb_addr,
  input  logic                data_wb_valid,
  input  logic [SQ_SEL-1:0]   data_wb_idx,
  input  logic [DATA_LEN-1:0] data_wb_data,
  input  logic [1:0]          commit_cnt,
  input  logic                flush,
  store_queue_fwd_if.master   mem,
  input  logic                ld_valid,
  input  logic [ADDR_LEN-1:0] ld_addr,
  input  logic [SQ_SEL:0]     ld_sq_tail,
  output logic                fwd_hit,
  output logic [DATA_LEN-1:0] fwd_data,
  output logic                fwd_stall,
  output logic [SQ_SEL:0]     dbg_head,
  output logic [SQ_SEL:0]     dbg_cmt,
  output logic [SQ_SEL:0]     dbg_tail,
  output logic [ROB_SEL-1:0]  dbg_head_rob_idx
);

  localparam int PW = SQ_SEL + 1;
  typedef logic [SQ_SEL:0]   ptr_t;
  typedef logic [SQ_SEL-1:0] idx_t;

  // Entry state
  logic [SQ_DEPTH-1:0] valid_q, addr_rdy_q, data_rdy_q, committed_q;
  logic [ADDR_LEN-1:0] addr_q [SQ_DEPTH];
  logic [DATA_LEN-1:0] data_q [SQ_DEPTH];
  logic [ROB_SEL-1:0]  rob_q  [SQ_DEPTH];
  ptr_t head_q, cmt_q, tail_q;

  // Next-state
  logic [SQ_DEPTH-1:0] valid_n, addr_rdy_n, data_rdy_n, committed_n;
  ptr_t head_n, cmt_n, tail_n;

  ptr_t       count, uncmt;
  logic [1:0] req;
  idx_t       head_i, cmt_i, cmt_i1, slot1_i, slot2_i;
  logic       mem_fire, addr_wb_en, data_wb_en;

  assign head_i  = head_q[SQ_SEL-1:0];
  assign cmt_i   = cmt_q[SQ_SEL-1:0];
  assign cmt_i1  = cmt_i + idx_t'(1);
  assign count   = tail_q - head_q;
  assign uncmt   = tail_q - cmt_q;
  assign sq_free = ptr_t'(SQ_DEPTH) - count;
  assign sq_empty = (count == '0);

  // Dispatch: whichever single slot is valid takes tail.
  assign req           = {1'b0, disp_valid_1} + {1'b0, disp_valid_2};
  assign disp_ack      = (req != 2'd0) && (PW'(req) <= sq_free) && !flush;
  assign disp_sq_idx_1 = tail_q;
  assign disp_sq_idx_2 = (disp_valid_1 && disp_valid_2) ? tail_q + ptr_t'(1) : tail_q;
  assign slot1_i       = disp_sq_idx_1[SQ_SEL-1:0];
  assign slot2_i       = disp_sq_idx_2[SQ_SEL-1:0];

  // Writebacks only land on live, uncommitted entries; a freshly allocated
  // entry is still invalid in its allocation cycle, so it is skipped too.
  assign addr_wb_en = addr_wb_valid && valid_q[addr_wb_idx] && !committed_q[addr_wb_idx];
  assign data_wb_en = data_wb_valid && valid_q[data_wb_idx] && !committed_q[data_wb_idx];

  // Drain channel
  assign mem.mem_req_valid = valid_q[head_i] && committed_q[head_i];
  assign mem.mem_req_addr  = addr_q[head_i];
  assign mem.mem_req_data  = data_q[head_i];
  assign mem_fire          = mem.mem_req_valid && mem.mem_req_ready;

  assign dbg_head         = head_q;
  assign dbg_cmt          = cmt_q;
  assign dbg_tail         = tail_q;
  assign dbg_head_rob_idx = rob_q[head_i];

  always_comb begin
    valid_n     = valid_q;
    addr_rdy_n  = addr_rdy_q;
    data_rdy_n  = data_rdy_q;
    committed_n = committed_q;
    head_n      = head_q;
    cmt_n       = cmt_q + ptr_t'(commit_cnt);
    tail_n      = tail_q;

    if (addr_wb_en) addr_rdy_n[addr_wb_idx] = 1'b1;
    if (data_wb_en) data_rdy_n[data_wb_idx] = 1'b1;

    if (commit_cnt != 2'd0)  committed_n[cmt_i]  = 1'b1;
    if (commit_cnt >= 2'd2)  committed_n[cmt_i1] = 1'b1;

    if (disp_ack) begin
      if (disp_valid_1) begin
        valid_n[slot1_i]     = 1'b1;
        addr_rdy_n[slot1_i]  = 1'b0;
        data_rdy_n[slot1_i]  = 1'b0;
        committed_n[slot1_i] = 1'b0;
      end
      if (disp_valid_2) begin
        valid_n[slot2_i]     = 1'b1;
        addr_rdy_n[slot2_i]  = 1'b0;
        data_rdy_n[slot2_i]  = 1'b0;
        committed_n[slot2_i] = 1'b0;
      end
      tail_n = tail_q + ptr_t'(req);
    end

    // Every live entry outside the committed region sits in [cmt_n, tail),
    // so dropping all live uncommitted entries is exactly that range.
    if (flush) begin
      tail_n = cmt_n;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (!committed_n[i]) valid_n[i] = 1'b0;
      end
    end

    if (mem_fire) begin
      valid_n[head_i] = 1'b0;
      head_n          = head_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      cmt_q       <= '0;
      tail_q      <= '0;
      valid_q     <= '0;
      addr_rdy_q  <= '0;
      data_rdy_q  <= '0;
      committed_q <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        rob_q[i]  <= '0;
      end
    end else begin
      head_q      <= head_n;
      cmt_q       <= cmt_n;
      tail_q      <= tail_n;
      valid_q     <= valid_n;
      addr_rdy_q  <= addr_rdy_n;
      data_rdy_q  <= data_rdy_n;
      committed_q <= committed_n;
      if (addr_wb_en) addr_q[addr_wb_idx] <= addr_wb_addr;
      if (data_wb_en) data_q[data_wb_idx] <= data_wb_data;
      if (disp_ack && disp_valid_1) rob_q[slot1_i] <= disp_rob_idx_1;
      if (disp_ack && disp_valid_2) rob_q[slot2_i] <= disp_rob_idx_2;
    end
  end

  // Forwarding: walk candidates oldest to youngest so the last match wins.
  ptr_t          span;
  idx_t          fidx;
  logic          any_unrdy, m_found, m_rdy;
  logic [DATA_LEN-1:0] m_data;

  assign span = ld_sq_tail - head_q;

  always_comb begin
    fidx      = '0;
    any_unrdy = 1'b0;
    m_found   = 1'b0;
    m_rdy     = 1'b0;
    m_data    = '0;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      fidx = head_i + idx_t'(k);
      if ((PW'(k) < span) && valid_q[fidx]) begin
        if (!addr_rdy_q[fidx]) begin
          any_unrdy = 1'b1;
        end else if (addr_q[fidx] == ld_addr) begin
          m_found = 1'b1;
          m_rdy   = data_rdy_q[fidx];
          m_data  = data_q[fidx];
        end
      end
    end
  end

  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    if (ld_valid) begin
      if (any_unrdy) begin
        fwd_stall = 1'b1;
      end else if (m_found) begin
        if (m_rdy) begin
          fwd_hit  = 1'b1;
          fwd_data = m_data;
        end else begin
          fwd_stall = 1'b1;
        end
      end
    end
  end

  // The ROB may never retire more stores than are allocated and uncommitted.
  commit_cnt_in_range: assert property (@(posedge clk) disable iff (reset)
    (PW'(commit_cnt) <= uncmt));

endmodule

// File: tb/tb_store_queue_fwd.sv
module tb_store_queue_fwd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        disp_valid_1, disp_valid_2;
  logic [5:0]  disp_rob_idx_1, disp_rob_idx_2;
  logic        disp_ack;
  logic [4:0]  disp_sq_idx_1, disp_sq_idx_2, sq_free;
  logic        sq_empty;
  logic        addr_wb_valid, data_wb_valid;
  logic [3:0]  addr_wb_idx, data_wb_idx;
  logic [31:0] addr_wb_addr, data_wb_data;
  logic [1:0]  commit_cnt;
  logic        flush;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [4:0]  ld_sq_tail;
  logic        fwd_hit, fwd_stall;
  logic [31:0] fwd_data;
  logic [4:0]  dbg_head, dbg_cmt, dbg_tail;
  logic [5:0]  dbg_head_rob_idx;

  int checks = 0;
  int failures = 0;

  store_queue_fwd_if #(.ADDR_LEN(32), .DATA_LEN(32)) mem_if ();

  store_queue_fwd dut (
    .clk              (clk),
    .reset            (reset),
    .disp_valid_1     (disp_valid_1),
    .disp_valid_2     (disp_valid_2),
    .disp_rob_idx_1   (disp_rob_idx_1),
    .disp_rob_idx_2   (disp_rob_idx_2),
    .disp_ack         (disp_ack),
    .disp_sq_idx_1    (disp_sq_idx_1),
    .disp_sq_idx_2    (disp_sq_idx_2),
    .sq_free          (sq_free),
    .sq_empty         (sq_empty),
    .addr_wb_valid    (addr_wb_valid),
    .addr_wb_idx      (addr_wb_idx),
    .addr_wb_addr     (addr_wb_addr),
    .data_wb_valid    (data_wb_valid),
    .data_wb_idx      (data_wb_idx),
    .data_wb_data     (data_wb_data),
    .commit_cnt       (commit_cnt),
    .flush            (flush),
    .mem              (mem_if),
    .ld_valid         (ld_valid),
    .ld_addr          (ld_addr),
    .ld_sq_tail       (ld_sq_tail),
    .fwd_hit          (fwd_hit),
    .fwd_data         (fwd_data),
    .fwd_stall        (fwd_stall),
    .dbg_head         (dbg_head),
    .dbg_cmt          (dbg_cmt),
    .dbg_tail         (dbg_tail),
    .dbg_head_rob_idx (dbg_head_rob_idx)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Check helper
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
    disp_valid_1  = 1'b0;
    disp_valid_2  = 1'b0;
    addr_wb_valid = 1'b0;
    data_wb_valid = 1'b0;
    commit_cnt    = 2'd0;
    flush         = 1'b0;
  endtask

  task automatic disp(input logic v1, input logic v2, input logic [5:0] r1, input logic [5:0] r2,
                      input logic exp_ack, input logic [4:0] e1, input logic [4:0] e2);
    disp_valid_1   = v1;
    disp_valid_2   = v2;
    disp_rob_idx_1 = r1;
    disp_rob_idx_2 = r2;
    #1;
    chk("disp_ack", disp_ack, exp_ack);
    chk("disp_sq_idx_1", disp_sq_idx_1, e1);
    chk("disp_sq_idx_2", disp_sq_idx_2, e2);
    tick();
  endtask

  task automatic wb(input logic do_a, input logic do_d, input logic [3:0] idx,
                    input logic [31:0] a, input logic [31:0] d);
    addr_wb_valid = do_a;
    addr_wb_idx   = idx;
    addr_wb_addr  = a;
    data_wb_valid = do_d;
    data_wb_idx   = idx;
    data_wb_data  = d;
    tick();
  endtask

  task automatic commit(input logic [1:0] n);
    commit_cnt = n;
    tick();
  endtask

  task automatic load(input logic v, input logic [31:0] a, input logic [4:0] t,
                      input logic exp_hit, input logic exp_stall, input logic [31:0] exp_data);
    ld_valid   = v;
    ld_addr    = a;
    ld_sq_tail = t;
    #1;
    chk("fwd_hit", fwd_hit, exp_hit);
    chk("fwd_stall", fwd_stall, exp_stall);
    if (exp_hit) chk("fwd_data", fwd_data, exp_data);
    tick();
  endtask

  task automatic expect_req(input logic [31:0] a, input logic [31:0] d);
    chk("mem_req_valid", mem_if.mem_req_valid, 1'b1);
    chk("mem_req_addr", mem_if.mem_req_addr, a);
    chk("mem_req_data", mem_if.mem_req_data, d);
  endtask

  // Directed sequence
  initial begin
    disp_valid_1 = 0; disp_valid_2 = 0; disp_rob_idx_1 = 0; disp_rob_idx_2 = 0;
    addr_wb_valid = 0; addr_wb_idx = 0; addr_wb_addr = 0;
    data_wb_valid = 0; data_wb_idx = 0; data_wb_data = 0;
    commit_cnt = 0; flush = 0; ld_valid = 0; ld_addr = 0; ld_sq_tail = 0;
    mem_if.mem_req_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_disp_ack", disp_ack, 1'b0);
    chk("rst_mem_req_valid", mem_if.mem_req_valid, 1'b0);
    chk("rst_fwd_hit", fwd_hit, 1'b0);
    chk("rst_fwd_stall", fwd_stall, 1'b0);
    chk("rst_sq_free", sq_free, 5'd16);
    chk("rst_sq_empty", sq_empty, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill with 8 dual dispatches
    for (int k = 0; k < 8; k++)
      disp(1'b1, 1'b1, 6'(2*k), 6'(2*k+1), 1'b1, 5'(2*k), 5'(2*k+1));
    #1;
    chk("full_sq_free", sq_free, 5'd0);
    chk("full_sq_empty", sq_empty, 1'b0);
    disp(1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 5'h10, 5'h10);

    // Writebacks and commits, drain held off
    for (int i = 0; i < 16; i++) wb(1'b1, 1'b1, 4'(i), 32'h100 + 32'(4*i), 32'(i));
    for (int i = 0; i < 8; i++) commit(2'd2);
    #1;
    chk("cmt_after_commits", dbg_cmt, 5'h10);
    chk("head_rob_idx", dbg_head_rob_idx, 6'd0);
    for (int c = 0; c < 5; c++) begin
      expect_req(32'h100, 32'd0);
      chk("hold_head", dbg_head, 5'd0);
      tick();
    end

    // Drain all 16 in order; reject a dual dispatch with one free slot
    for (int i = 0; i < 16; i++) begin
      mem_if.mem_req_ready = 1'b1;
      #1;
      expect_req(32'h100 + 32'(4*i), 32'(i));
      if (i == 1) begin
        chk("one_free_sq_free", sq_free, 5'd1);
        disp(1'b1, 1'b1, 6'd0, 6'd0, 1'b0, 5'h10, 5'h11);
      end else begin
        tick();
      end
    end
    mem_if.mem_req_ready = 1'b0;
    #1;
    chk("drained_empty", sq_empty, 1'b1);
    chk("drained_free", sq_free, 5'd16);
    chk("drained_req_valid", mem_if.mem_req_valid, 1'b0);
    chk("tail_unchanged", disp_sq_idx_1, 5'h10);

    // Refill across the wrap
    for (int k = 0; k < 8; k++)
      disp(1'b1, 1'b1, 6'd1, 6'd2, 1'b1, 5'h10 + 5'(2*k), 5'h11 + 5'(2*k));
    for (int i = 0; i < 16; i++) wb(1'b1, 1'b1, 4'(i), 32'h500 + 32'(4*i), 32'hA0 + 32'(i));
    for (int i = 0; i < 8; i++) commit(2'd2);
    for (int i = 0; i < 16; i++) begin
      mem_if.mem_req_ready = 1'b1;
      #1;
      expect_req(32'h500 + 32'(4*i), 32'hA0 + 32'(i));
      tick();
    end
    mem_if.mem_req_ready = 1'b0;
    #1;
    chk("wrap_empty", sq_empty, 1'b1);
    chk("wrap_head", dbg_head, 5'd0);
    chk("wrap_tail", dbg_tail, 5'd0);

    // Forwarding: entries 0,1,2
    disp(1'b1, 1'b1, 6'd3, 6'd4, 1'b1, 5'd0, 5'd1);
    disp(1'b1, 1'b0, 6'd5, 6'd0, 1'b1, 5'd2, 5'd2);
    wb(1'b1, 1'b1, 4'd0, 32'h200, 32'h11);
    wb(1'b1, 1'b0, 4'd2, 32'h200, 32'h0);
    load(1'b1, 32'h200, 5'd3, 1'b0, 1'b1, 32'h0);     // entry 1 addr unknown
    wb(1'b1, 1'b1, 4'd1, 32'h300, 32'h22);
    load(1'b1, 32'h200, 5'd3, 1'b0, 1'b1, 32'h0);     // entry 2 data missing
    wb(1'b0, 1'b1, 4'd2, 32'h0, 32'h33);
    load(1'b1, 32'h200, 5'd3, 1'b1, 1'b0, 32'h33);
    load(1'b1, 32'h200, 5'd2, 1'b1, 1'b0, 32'h11);
    load(1'b1, 32'h400, 5'd3, 1'b0, 1'b0, 32'h0);
    load(1'b0, 32'h200, 5'd3, 1'b0, 1'b0, 32'h0);
    commit(2'd2);
    commit(2'd1);
    load(1'b1, 32'h200, 5'd3, 1'b1, 1'b0, 32'h33);    // committed still forward
    load(1'b1, 32'h300, 5'd1, 1'b0, 1'b0, 32'h0);     // entry 1 outside range
    ld_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_if.mem_req_ready = 1'b1;
      #1;
      case (i)
        0:       expect_req(32'h200, 32'h11);
        1:       expect_req(32'h300, 32'h22);
        default: expect_req(32'h200, 32'h33);
      endcase
      tick();
    end
    mem_if.mem_req_ready = 1'b0;

    // Flush
    reset = 1'b1;
    #2;
    reset = 1'b0;
    disp(1'b1, 1'b1, 6'd0, 6'd1, 1'b1, 5'd0, 5'd1);
    disp(1'b1, 1'b1, 6'd2, 6'd3, 1'b1, 5'd2, 5'd3);
    disp(1'b1, 1'b1, 6'd4, 6'd5, 1'b1, 5'd4, 5'd5);
    for (int i = 0; i < 3; i++) wb(1'b1, 1'b1, 4'(i), 32'h600 + 32'(4*i), 32'h60 + 32'(i));
    commit(2'd2);
    flush = 1'b1;
    commit_cnt = 2'd1;
    disp(1'b1, 1'b0, 6'd9, 6'd0, 1'b0, 5'd6, 5'd6);
    #1;
    chk("flush_tail", dbg_tail, 5'd3);
    chk("flush_cmt", dbg_cmt, 5'd3);
    chk("flush_sq_free", sq_free, 5'd13);
    wb(1'b1, 1'b1, 4'd4, 32'h700, 32'h99);            // flushed entry: ignored
    chk("flushed_wb_free", sq_free, 5'd13);
    data_wb_valid = 1'b1;                             // same-cycle alloc: ignored
    data_wb_idx   = 4'd3;
    data_wb_data  = 32'h77;
    disp(1'b1, 1'b0, 6'h2A, 6'd0, 1'b1, 5'd3, 5'd3);
    wb(1'b1, 1'b0, 4'd3, 32'h700, 32'h0);
    load(1'b1, 32'h700, 5'd4, 1'b0, 1'b1, 32'h0);
    load(1'b1, 32'h604, 5'd3, 1'b1, 1'b0, 32'h61);
    ld_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_if.mem_req_ready = 1'b1;
      #1;
      expect_req(32'h600 + 32'(4*i), 32'h60 + 32'(i));
      tick();
    end
    mem_if.mem_req_ready = 1'b0;
    #1;
    chk("post_flush_req_valid", mem_if.mem_req_valid, 1'b0);
    chk("post_flush_free", sq_free, 5'd15);

    // Held request, then reset mid-hold
    wb(1'b0, 1'b1, 4'd3, 32'h0, 32'h77);
    commit(2'd1);
    for (int c = 0; c < 5; c++) begin
      expect_req(32'h700, 32'h77);
      chk("hold2_head", dbg_head, 5'd3);
      chk("hold2_rob", dbg_head_rob_idx, 6'h2A);
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_req_valid", mem_if.mem_req_valid, 1'b0);
    chk("midrst_sq_free", sq_free, 5'd16);
    chk("midrst_sq_empty", sq_empty, 1'b1);
    chk("midrst_tail", dbg_tail, 5'd0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
